seq_divider: RTL and testbench

//   Iterative radix-2 restoring unsigned divider: 2*WIDTH-bit dividend / WIDTH-bit divisor ->

---
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// One quotient bit per clock, valid/ready on both sides, one operation in flight.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [CNT_W-1:0]   count;

  logic [WIDTH-1:0]   dvd_hi;
  logic [WIDTH-1:0]   dvd_lo;
  logic [WIDTH+1:0]   trial;
  logic               borrow;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;

  assign dvd_hi   = dividend_q[2*WIDTH-1:WIDTH];
  assign dvd_lo   = dividend_q[WIDTH-1:0];
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // One restoring step: shift {R,Q} left, try subtracting the divisor, keep the
  // difference only when it did not borrow.
  // NOTE: combinational logic uses blocking '=' and assigns every output on
  // every path, so no latch is inferred; clocked state below uses '<=' only.
  always_comb begin
    trial    = {rem_q, quo_q[WIDTH-1]} - {2'b00, divisor_q};
    borrow   = trial[WIDTH+1];
    rem_next = borrow ? {rem_q[WIDTH-1:0], quo_q[WIDTH-1]} : trial[WIDTH:0];
    quo_next = {quo_q[WIDTH-2:0], ~borrow};
  end

  // NOTE: every register here, including the operand and datapath registers,
  // is cleared by reset so no X can ever reach the result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dividend_q <= dividend;
            divisor_q  <= divisor;
            state      <= CHECK;
          end
        end

        // Divide-by-zero is tested first so it wins over overflow.
        CHECK: begin
          if (divisor_q == '0) begin
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
            quotient    <= '1;
            remainder   <= dvd_lo;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else if (dvd_hi >= divisor_q) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
            quotient    <= '1;
            remainder   <= '0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            rem_q <= {1'b0, dvd_hi};
            quo_q <= dvd_lo;
            count <= CNT_W'(WIDTH - 1);
            state <= RUN;
          end
        end

        RUN: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (count == '0) begin
            quotient    <= quo_next;
            remainder   <= rem_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and randomised bench for seq_divider at WIDTH=32, with hand-written
// backpressure, ignored-input and mid-run reset sequences.
module tb_seq_divider;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands until accepted; returns just after the accepting edge.
  task automatic start_op(input logic [63:0] dvd, input logic [31:0] dvs, output bit ok);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      check("in_ready_wait", 64'd0, 64'd1);
      ok = 1'b0;
      return;
    end
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
    ok = 1'b1;
  endtask

  // lat counts clock edges from (and including) the accepting edge.
  task automatic wait_result(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) check("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"},   64'(in_ready),  64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit ok;
    int lat;
    start_op(v.dvd, v.dvs, ok);
    if (!ok) return;
    wait_result(1, lat);
    check({tag, "_latency"},   64'(lat),         64'(v.lat));
    check({tag, "_quotient"},  64'(quotient),    64'(v.q));
    check({tag, "_remainder"}, 64'(remainder),   64'(v.r));
    check({tag, "_dz"},        64'(div_by_zero), 64'(v.dz));
    check({tag, "_ov"},        64'(overflow),    64'(v.ov));
    release_result(tag);
  endtask

  initial begin
    bit          ok;
    int          lat;
    logic [31:0] dvs;
    logic [63:0] dvd;
    logic [63:0] exp_q;
    logic [63:0] exp_r;

    vecs.push_back('{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34});
    vecs.push_back('{64'hFFFFFFFE_00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 34});
    vecs.push_back('{64'h0000_0000_0000_1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1'b0, 2});
    vecs.push_back('{64'h1_00000000, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 2});
    vecs.push_back('{64'hFFFFFFFF_00000005, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 2});
    vecs.push_back('{64'h5_00000000, 32'd5, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 2});
    vecs.push_back('{64'h4_FFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd4, 1'b0, 1'b0, 34});
    vecs.push_back('{64'h0_FFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 34});
    vecs.push_back('{64'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1'b0, 34});
    vecs.push_back('{64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 34});
    vecs.push_back('{64'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 34});

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_in_ready",  64'(in_ready),    64'd1);
    check("rst_out_valid", 64'(out_valid),   64'd0);
    check("rst_busy",      64'(busy),        64'd0);
    check("rst_quotient",  64'(quotient),    64'd0);
    check("rst_remainder", 64'(remainder),   64'd0);
    check("rst_flags",     64'({div_by_zero, overflow}), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure plus in_valid pulses during RUN that must be ignored.
    start_op(64'd100, 32'd7, ok);
    if (ok) begin
      repeat (3) begin @(posedge clk); #1; end
      dividend = 64'd1000;
      divisor  = 32'd3;
      in_valid = 1'b1;
      check("run_in_ready", 64'(in_ready), 64'd0);
      check("run_busy",     64'(busy),     64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_result(5, lat);
      check("bp_latency", 64'(lat), 64'd34);
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        check("bp_valid_hold", 64'(out_valid), 64'd1);
        check("bp_in_ready",   64'(in_ready),  64'd0);
        check("bp_quotient",   64'(quotient),  64'd14);
        check("bp_remainder",  64'(remainder), 64'd2);
        check("bp_flags",      64'({div_by_zero, overflow}), 64'd0);
      end
      release_result("bp");
    end

    // Asynchronous reset in the middle of RUN.
    start_op(64'd123456789, 32'd7, ok);
    if (ok) begin
      repeat (9) begin @(posedge clk); #1; end
      check("pre_rst_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_busy",      64'(busy),      64'd0);
      check("mid_rst_in_ready",  64'(in_ready),  64'd1);
      check("mid_rst_quotient",  64'(quotient),  64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_vec('{64'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 34}, "post_rst");
    end

    // Random operands with dividend[63:32] < divisor, against a reference division.
    for (int i = 0; i < 1500; i++) begin
      dvs = $urandom >> $urandom_range(0, 31);
      if (dvs == 0) dvs = 32'd1;
      dvd = {$urandom % dvs, $urandom};
      exp_q = dvd / {32'd0, dvs};
      exp_r = dvd % {32'd0, dvs};
      start_op(dvd, dvs, ok);
      if (!ok) break;
      wait_result(1, lat);
      check("rand_quotient",  64'(quotient),  exp_q);
      check("rand_remainder", 64'(remainder), exp_r);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
